mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a CPU port and a host port onto a single memory
// port. The FSM steps IDLE -> ACCESS (MEM_LAT cycles) -> ACK (1 cycle) -> IDLE.
// Every output is registered.
// Optional feature: define ARB_RR_EN to break CPU/host ties round-robin.
// Without ARB_RR_EN the CPU always wins a tie.
module mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cpustate,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_ack,
  output logic          host_err,
  output logic [DW-1:0] host_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = 4;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;       // 1 = host owns the transaction
  logic          req_we_q, req_we_d;     // the owner asked for a write
  logic          rej_q, rej_d;           // host write refused in CHECK mode
  logic          mem_cs_q, mem_cs_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          host_gnt_q, host_gnt_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          host_ack_q, host_ack_d;
  logic          host_err_q, host_err_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          busy_q, busy_d;
  logic          cpu_elig, host_elig, pick_host, wr_sel;
`ifdef ARB_RR_EN
  logic          last_host_q, last_host_d;
`endif

  // Eligibility by CPU mode and winner selection on a tie
  always_comb begin
    cpu_elig  = cpu_req && (cpustate == 2'b11);
    host_elig = host_req && (cpustate != 2'b00);
`ifdef ARB_RR_EN
    pick_host = host_elig && (!cpu_elig || !last_host_q);
`else
    pick_host = host_elig && !cpu_elig;
`endif
    wr_sel    = pick_host ? host_we : cpu_we;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    req_we_d     = req_we_q;
    rej_d        = rej_q;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_gnt_d    = cpu_gnt_q;
    host_gnt_d   = host_gnt_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    busy_d       = busy_q;
`ifdef ARB_RR_EN
    last_host_d  = last_host_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cpu_elig || host_elig) begin
          state_d     = S_ACCESS;
          cnt_d       = CW'(MEM_LAT - 1);
          owner_d     = pick_host;
          req_we_d    = wr_sel;
          rej_d       = pick_host && host_we && (cpustate == 2'b10);
          mem_cs_d    = 1'b1;
          mem_we_d    = wr_sel && !(pick_host && host_we && (cpustate == 2'b10));
          mem_addr_d  = pick_host ? host_addr : cpu_addr;
          mem_wdata_d = pick_host ? host_wdata : cpu_wdata;
          cpu_gnt_d   = !pick_host;
          host_gnt_d  = pick_host;
          busy_d      = 1'b1;
`ifdef ARB_RR_EN
          last_host_d = pick_host;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d    = S_ACK;
          mem_cs_d   = 1'b0;
          mem_we_d   = 1'b0;
          cpu_gnt_d  = 1'b0;
          host_gnt_d = 1'b0;
          cpu_ack_d  = !owner_q;
          host_ack_d = owner_q;
          host_err_d = owner_q && rej_q;
          if (!req_we_q) begin
            if (owner_q) host_rdata_d = mem_rdata;
            else         cpu_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      req_we_q     <= 1'b0;
      rej_q        <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      host_gnt_q   <= 1'b0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      busy_q       <= 1'b0;
`ifdef ARB_RR_EN
      last_host_q  <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      req_we_q     <= req_we_d;
      rej_q        <= rej_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      host_gnt_q   <= host_gnt_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      busy_q       <= busy_d;
`ifdef ARB_RR_EN
      last_host_q  <= last_host_d;
`endif
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_gnt   = host_gnt_q;
  assign host_ack   = host_ack_q;
  assign host_err   = host_err_q;
  assign host_rdata = host_rdata_q;
  assign mem_cs     = mem_cs_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with MEM_LAT=2.
// Inputs are driven on the falling edge and outputs are sampled there.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cpustate;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [15:0] cpu_addr, host_addr, mem_addr;
  logic [7:0]  cpu_wdata, host_wdata, mem_wdata, mem_rdata, cpu_rdata, host_rdata;
  logic        cpu_gnt, cpu_ack, host_gnt, host_ack, host_err, mem_cs, mem_we, busy;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.AW(16), .DW(8), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .cpustate(cpustate),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_gnt"},  32'(cpu_gnt),    32'h0);
    check({tag, "_host_gnt"}, 32'(host_gnt),   32'h0);
    check({tag, "_cpu_ack"},  32'(cpu_ack),    32'h0);
    check({tag, "_host_ack"}, 32'(host_ack),   32'h0);
    check({tag, "_host_err"}, 32'(host_err),   32'h0);
    check({tag, "_mem_cs"},   32'(mem_cs),     32'h0);
    check({tag, "_mem_we"},   32'(mem_we),     32'h0);
    check({tag, "_busy"},     32'(busy),       32'h0);
    check({tag, "_addr"},     32'(mem_addr),   32'h0);
    check({tag, "_wdata"},    32'(mem_wdata),  32'h0);
    check({tag, "_crdata"},   32'(cpu_rdata),  32'h0);
    check({tag, "_hrdata"},   32'(host_rdata), 32'h0);
  endtask

  initial begin
    rst = 1'b0; cpustate = 2'b00;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    mem_rdata = 8'hA5;
    #12;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b1;
    step();

    // CPU read in RUN mode
    cpustate = 2'b11; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    step();
    check("rd_c1_gnt", 32'(cpu_gnt), 32'h1);
    check("rd_c1_cs", 32'(mem_cs), 32'h1);
    check("rd_c1_addr", 32'(mem_addr), 32'h0010);
    check("rd_c1_we", 32'(mem_we), 32'h0);
    check("rd_c1_busy", 32'(busy), 32'h1);
    cpu_req = 1'b0;
    step();
    check("rd_c2_gnt", 32'(cpu_gnt), 32'h1);
    check("rd_c2_cs", 32'(mem_cs), 32'h1);
    check("rd_c2_ack", 32'(cpu_ack), 32'h0);
    step();
    check("rd_c3_ack", 32'(cpu_ack), 32'h1);
    check("rd_c3_gnt", 32'(cpu_gnt), 32'h0);
    check("rd_c3_cs", 32'(mem_cs), 32'h0);
    check("rd_c3_rdata", 32'(cpu_rdata), 32'hA5);
    step();
    check("rd_c4_ack", 32'(cpu_ack), 32'h0);
    check("rd_c4_busy", 32'(busy), 32'h0);
    check("rd_c4_hold", 32'(cpu_rdata), 32'hA5);

    // Host write in IN mode
    cpustate = 2'b01; host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0003; host_wdata = 8'h3C;
    step();
    check("hw_c1_gnt", 32'(host_gnt), 32'h1);
    check("hw_c1_we", 32'(mem_we), 32'h1);
    check("hw_c1_addr", 32'(mem_addr), 32'h0003);
    check("hw_c1_wdata", 32'(mem_wdata), 32'h3C);
    host_req = 1'b0;
    step();
    check("hw_c2_we", 32'(mem_we), 32'h1);
    step();
    check("hw_c3_ack", 32'(host_ack), 32'h1);
    check("hw_c3_err", 32'(host_err), 32'h0);
    check("hw_c3_we", 32'(mem_we), 32'h0);
    step();
    check("hw_c4_ack", 32'(host_ack), 32'h0);

    // Host write in CHECK mode is refused
    cpustate = 2'b10; host_req = 1'b1; host_we = 1'b1;
    step();
    check("hc_c1_gnt", 32'(host_gnt), 32'h1);
    check("hc_c1_we", 32'(mem_we), 32'h0);
    host_req = 1'b0;
    step();
    check("hc_c2_we", 32'(mem_we), 32'h0);
    step();
    check("hc_c3_ack", 32'(host_ack), 32'h1);
    check("hc_c3_err", 32'(host_err), 32'h1);
    check("hc_c3_hrdata", 32'(host_rdata), 32'h00);
    check("hc_c3_crdata", 32'(cpu_rdata), 32'hA5);
    step();
    check("hc_c4_err", 32'(host_err), 32'h0);

    // Both requesting continuously in RUN mode
    cpustate = 2'b11; cpu_req = 1'b1; cpu_we = 1'b0; host_req = 1'b1; host_we = 1'b0;
    mem_rdata = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      logic exp_host;
`ifdef ARB_RR_EN
      exp_host = (i % 2) == 1;
`else
      exp_host = 1'b0;
`endif
      step();
      check($sformatf("tie%0d_cgnt", i), 32'(cpu_gnt), 32'(!exp_host));
      check($sformatf("tie%0d_hgnt", i), 32'(host_gnt), 32'(exp_host));
      step();
      step();
      check($sformatf("tie%0d_cack", i), 32'(cpu_ack), 32'(!exp_host));
      check($sformatf("tie%0d_hack", i), 32'(host_ack), 32'(exp_host));
      if (!exp_host) check($sformatf("tie%0d_crd", i), 32'(cpu_rdata), 32'h5A);
      else           check($sformatf("tie%0d_hrd", i), 32'(host_rdata), 32'h5A);
      step();
      check($sformatf("tie%0d_idle", i), 32'(busy), 32'h0);
    end

    // CPU request ignored outside RUN mode
    host_req = 1'b0; cpustate = 2'b01; cpu_req = 1'b1;
    step();
    check("in_cpu_gnt", 32'(cpu_gnt), 32'h0);
    check("in_busy", 32'(busy), 32'h0);
    step();
    check("in_busy2", 32'(busy), 32'h0);
    cpustate = 2'b11;
    step();
    check("run_cpu_gnt", 32'(cpu_gnt), 32'h1);
    cpu_req = 1'b0; cpustate = 2'b00;
    step();
    step();
    check("run_cpu_ack", 32'(cpu_ack), 32'h1);
    step();

    // Reset in the second ACCESS cycle, then a clean host read
    cpustate = 2'b01; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0044; mem_rdata = 8'h77;
    step();
    check("rs_c1_gnt", 32'(host_gnt), 32'h1);
    step();
    check("rs_c2_cs", 32'(mem_cs), 32'h1);
    rst = 1'b0;
    #1;
    check_all_zero("rs_async");
    step();
    check("rs_noack", 32'(host_ack), 32'h0);
    rst = 1'b1;
    step();
    check("rs_new_gnt", 32'(host_gnt), 32'h1);
    check("rs_new_addr", 32'(mem_addr), 32'h0044);
    host_req = 1'b0;
    step();
    step();
    check("rs_new_ack", 32'(host_ack), 32'h1);
    check("rs_new_rdata", 32'(host_rdata), 32'h77);
    step();
    check("rs_end_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
